// File: rtl/mem_arb_pkg.sv
// Shared state encoding and counter widths for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  localparam int unsigned LAT_CNT_W    = 3;
  localparam int unsigned STARVE_CNT_W = 2;

endpackage

// File: rtl/arb_sat_ctr.sv
// Saturating up-counter with synchronous clear; tracks consecutive data grants that
// bypassed a waiting fetch.
module arb_sat_ctr #(
  parameter int unsigned W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_max)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one memory with a fixed access latency.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LAT        = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_dm_req,
  input  logic              i_dm_wr,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_if_grant,
  output logic              o_dm_grant,
  output logic              o_if_done,
  output logic              o_dm_done,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_err
);

  if (LAT < 2 || LAT > 7) begin : g_bad_lat
    $error("mem_port_arbiter: LAT must be within 2..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX >= (1 << STARVE_CNT_W)) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX does not fit the starvation counter");
  end

  localparam logic [LAT_CNT_W-1:0] LatLast = LAT_CNT_W'(LAT - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic                 w_lat_last;
  logic                 w_if_starved;
  logic                 w_if_grant;
  logic                 w_dm_grant;

  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] StarveMax = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] w_starve_cnt;

  arb_sat_ctr #(
    .W(STARVE_CNT_W)
  ) u_starve_ctr (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(w_if_grant),
    .i_inc(w_dm_grant & i_if_req),
    .i_max(StarveMax),
    .o_cnt(w_starve_cnt)
  );

  assign w_if_starved = i_if_req && (w_starve_cnt == StarveMax);
`else
  assign w_if_starved = 1'b0;
`endif

  assign w_lat_last = (r_lat_cnt == LatLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dm_grant) begin
          w_state_next = BUSY_DM;
        end else if (w_if_grant) begin
          w_state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (w_lat_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Every strobe is gated by reset so an access aborted by rst never reports done.
  always_comb begin
    w_dm_grant = 1'b0;
    w_if_grant = 1'b0;
    o_if_done  = 1'b0;
    o_dm_done  = 1'b0;
    o_busy     = 1'b0;
    o_err      = 1'b0;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          w_dm_grant = i_dm_req && !w_if_starved;
          w_if_grant = i_if_req && !w_dm_grant;
        end
        BUSY_IF: begin
          o_busy    = 1'b1;
          o_if_done = w_lat_last;
        end
        BUSY_DM: begin
          o_busy    = 1'b1;
          o_dm_done = w_lat_last;
        end
        default: o_err = 1'b1;
      endcase
    end
  end

  assign o_if_grant = w_if_grant;
  assign o_dm_grant = w_dm_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lat_cnt <= '0;
    end else if (w_if_grant || w_dm_grant) begin
      r_lat_cnt <= LAT_CNT_W'(1);
    end else if (r_state == BUSY_IF || r_state == BUSY_DM) begin
      r_lat_cnt <= w_lat_last ? '0 : r_lat_cnt + LAT_CNT_W'(1);
    end
  end

  // Command fields hold from the cycle after grant until the next grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_if_grant | w_dm_grant;
      if (w_dm_grant) begin
        r_mem_wr    <= i_dm_wr;
        r_mem_addr  <= i_dm_addr;
        r_mem_wdata <= i_dm_wdata;
      end else if (w_if_grant) begin
        r_mem_wr    <= 1'b0;
        r_mem_addr  <= i_if_addr;
        r_mem_wdata <= '0;
      end
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
